// File: rtl/noc_out_port_scheduler.sv
// Wormhole output-port scheduler: round-robin pick of a requesting input, locks the xbar for a whole packet.
// Latency: arbitration takes one IDLE cycle; first flit grant earliest the cycle after the winning req is sampled.
// Backpressure: grants stall (all state held) while dcts is low or the owning source FIFO is empty.
module noc_out_port_scheduler #(
  parameter int N_PORTS = 5,
  parameter int LEN_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS*LEN_W-1:0]   len_in,
  input  logic [N_PORTS-1:0]         src_valid,
  input  logic                       dcts,
  output logic [N_PORTS-1:0]         grant,
  output logic [N_PORTS-1:0]         sel,
  output logic                       busy,
  output logic                       pkt_done
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [PW-1:0]  PTR_LAST = PW'(N_PORTS - 1);
  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      owner, owner_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [LEN_W:0]     cnt, cnt_nxt;
  logic [N_PORTS-1:0] sel_nxt;
  logic               busy_nxt;
  logic               found;
  logic [PW-1:0]      win;
  logic [LEN_W-1:0]   win_len;

  // Round-robin search starting just after the last serviced port.
  always_comb begin
    int idx;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    win_len = len_in[int'(win)*LEN_W +: LEN_W];
  end

  // Flit grants and next-state logic; grant is suppressed while reset is asserted.
  always_comb begin
    grant     = '0;
    pkt_done  = 1'b0;
    state_nxt = state;
    sel_nxt   = sel;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = XFER;
          sel_nxt        = '0;
          sel_nxt[win]   = 1'b1;
          owner_nxt      = win;
          // One extra count for the header flit; the carry bit keeps a max length from wrapping.
          cnt_nxt        = {1'b0, win_len} + CNT_ONE;
          busy_nxt       = 1'b1;
        end
      end
      XFER: begin
        if (!rst) grant[owner] = src_valid[owner] & dcts;
        if (|grant) begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            pkt_done  = 1'b1;
            state_nxt = IDLE;
            sel_nxt   = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = owner;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset (aborts any packet in flight).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      owner <= '0;
      cnt   <= '0;
      ptr   <= PTR_LAST;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_noc_out_port_scheduler.sv
// Bench for noc_out_port_scheduler: per-cycle vector table through a scoreboard queue,
// plus a long max-length packet sequence.
module tb_noc_out_port_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [59:0] len_in;
  logic [4:0]  src_valid;
  logic        dcts;
  logic [4:0]  grant;
  logic [4:0]  sel;
  logic        busy;
  logic        pkt_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [59:0] len;
    logic [4:0]  sv;
    logic        dcts;
    logic [4:0]  g;
    logic [4:0]  s;
    logic        b;
    logic        pd;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  noc_out_port_scheduler #(.N_PORTS(5), .LEN_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len_in    (len_in),
    .src_valid (src_valid),
    .dcts      (dcts),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  function automatic logic [59:0] lens(input int p, input int l);
    logic [59:0] r;
    r = '0;
    r[p*12 +: 12] = l[11:0];
    return r;
  endfunction

  task automatic add(input logic r, input logic [4:0] rq, input logic [59:0] ln, input logic [4:0] sv,
                     input logic dc, input logic [4:0] g, input logic [4:0] s, input logic b, input logic pd);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln; v.sv = sv; v.dcts = dc;
    v.g = g; v.s = s; v.b = b; v.pd = pd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one vector after the edge, queue its expectation, compare mid-cycle.
  task automatic run_vec(input int i, input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; req = v.req; len_in = v.len; src_valid = v.sv; dcts = v.dcts;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("r%0d grant", i), 32'(grant), 32'(e.g));
    chk($sformatf("r%0d sel", i), 32'(sel), 32'(e.s));
    chk($sformatf("r%0d busy", i), 32'(busy), 32'(e.b));
    chk($sformatf("r%0d pkt_done", i), 32'(pkt_done), 32'(e.pd));
    chk($sformatf("r%0d grant_outside_sel", i), 32'(grant & ~sel), 32'd0);
    chk($sformatf("r%0d busy_vs_sel", i), 32'(busy), 32'(|sel));
  endtask

  initial begin
    int w[5];
    int ng;
    int pd_at;
    bit done;

    rst = 1'b1; req = '0; len_in = '0; src_valid = '0; dcts = 1'b0;

    // T1: reset with all requesting, then port 0 wins first
    add(1, 5'h1f, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(1, 5'h1f, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h1f, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h1f, '0, 5'h1f, 1, 5'h01, 5'h01, 1, 1);
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // T2: single 4-flit packet on port 3
    add(0, 5'h08, lens(3, 3), 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h08, lens(3, 3), 5'h1f, 1, 5'h08, 5'h08, 1, 0);
    add(0, 5'h08, lens(3, 3), 5'h1f, 1, 5'h08, 5'h08, 1, 0);
    add(0, 5'h08, lens(3, 3), 5'h1f, 1, 5'h08, 5'h08, 1, 0);
    add(0, 5'h08, lens(3, 3), 5'h1f, 1, 5'h08, 5'h08, 1, 1);
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // reset pointer back to port 4 before the rotation check
    add(1, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // T3: round robin over ports 0,2,4 with header-only packets
    w = '{0, 2, 4, 0, 2};
    for (int k = 0; k < 5; k++) begin
      add(0, 5'h15, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
      add(0, 5'h15, '0, 5'h1f, 1, 5'(1 << w[k]), 5'(1 << w[k]), 1, 1);
    end
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // T4: dcts stall mid-packet on port 1; len change during packet ignored
    add(0, 5'h02, lens(1, 2), 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h00, lens(1, 2), 5'h1f, 1, 5'h02, 5'h02, 1, 0);
    for (int k = 0; k < 5; k++)
      add(0, 5'h00, lens(1, 7), 5'h1f, 0, 5'h00, 5'h02, 1, 0);
    add(0, 5'h00, lens(1, 7), 5'h1f, 1, 5'h02, 5'h02, 1, 0);
    add(0, 5'h00, lens(1, 7), 5'h1f, 1, 5'h02, 5'h02, 1, 1);
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // T5: port 4 source runs dry while port 0 requests; lock holds
    add(0, 5'h10, lens(4, 2), 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h01, '0, 5'h1f, 1, 5'h10, 5'h10, 1, 0);
    for (int k = 0; k < 3; k++)
      add(0, 5'h01, '0, 5'h0f, 1, 5'h00, 5'h10, 1, 0);
    add(0, 5'h01, '0, 5'h1f, 1, 5'h10, 5'h10, 1, 0);
    add(0, 5'h01, '0, 5'h1f, 1, 5'h10, 5'h10, 1, 1);
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    // T6: reset during second flit of a 5-flit packet on port 2
    add(0, 5'h04, lens(2, 4), 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h04, lens(2, 4), 5'h1f, 1, 5'h04, 5'h04, 1, 0);
    add(1, 5'h04, lens(2, 4), 5'h1f, 1, 5'h00, 5'h04, 1, 0);
    add(0, 5'h05, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);
    add(0, 5'h05, '0, 5'h1f, 1, 5'h01, 5'h01, 1, 1);
    add(0, 5'h00, '0, 5'h1f, 1, 5'h00, 5'h00, 0, 0);

    @(posedge clk);
    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Max-length packet: 4095 + header must give exactly 4096 grants, pkt_done only on the last
    @(posedge clk);
    #1;
    rst = 1'b0; req = 5'h01; len_in = lens(0, 4095); src_valid = 5'h1f; dcts = 1'b1;
    @(negedge clk);
    chk("maxlen idle grant", 32'(grant), 32'd0);
    @(posedge clk);
    #1;
    req = 5'h00; len_in = '0;
    ng = 0; pd_at = 0; done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (grant == 5'h01) ng++;
      if (pkt_done) begin
        done  = 1'b1;
        pd_at = ng;
      end
    end
    chk("maxlen pkt_done seen", 32'(done), 32'd1);
    chk("maxlen grant count", 32'(ng), 32'd4096);
    chk("maxlen pkt_done position", 32'(pd_at), 32'd4096);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("maxlen busy after", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
